// File: rtl/apb_requester_if.sv
// Bundle of the command, response and APB4 signals around apb_requester.
// master = the requester side; slave = whoever plays host and completer.
interface apb_requester_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic                      cmd_write;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic [DATA_WIDTH/8-1:0]   cmd_strb;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_slverr;
  logic                      rsp_timeout;

  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_WIDTH-1:0]     PADDR;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic                      PREADY;
  logic                      PSLVERR;
  logic [DATA_WIDTH-1:0]     PRDATA;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  rsp_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output rsp_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb_requester.sv
// APB4 requester: one valid/ready command becomes one APB transfer, whose
// result (or a PREADY timeout) is returned on a valid/ready response channel.
module apb_requester #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  apb_requester_if.master bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        // APB outputs are loaded here so they are already registered in SETUP.
        if (bus.cmd_valid) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = bus.cmd_addr;
          pwrite_d  = bus.cmd_write;
          pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
          pstrb_d   = bus.cmd_write ? bus.cmd_strb  : '0;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ACCESS: begin
        if (bus.PREADY) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rsp_slverr_d  = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LIMIT)) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready   = (state_q == IDLE) && PRESETn;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_slverr  = rsp_slverr_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  a_penable_needs_psel: assert property (@(posedge PCLK) disable iff (!PRESETn)
    bus.PENABLE |-> bus.PSEL);

  a_rsp_hold: assert property (@(posedge PCLK) disable iff (!PRESETn)
    (bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable(bus.rsp_rdata) && $stable(bus.rsp_slverr) &&
       $stable(bus.rsp_timeout)));

  a_timeout_fields: assert property (@(posedge PCLK) disable iff (!PRESETn)
    (bus.rsp_valid && bus.rsp_timeout) |-> (bus.rsp_slverr && (bus.rsp_rdata == '0)));
endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: a transaction-timeline model predicts every output
// each cycle; directed scenarios plus random traffic drive the command side.
module tb_apb_requester;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int T  = 4;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_requester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: a transfer is a timeline counted from its accept edge. Cycle 1 is
  // SETUP, access runs until done_k, response shows from done_k until taken.
  bit            m_busy;
  int            m_k, m_w, m_done_k;
  logic [AW-1:0] m_paddr;
  logic          m_pwrite;
  logic [DW-1:0] m_pwdata;
  logic [SW-1:0] m_pstrb;
  logic [DW-1:0] m_rdata;
  logic          m_slverr, m_to;
  int            acc_cyc, hs_cyc;

  bit            seen;
  int            obs_lat;
  logic [DW-1:0] obs_rdata;
  logic          obs_slverr, obs_to;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_w = 0; m_done_k = 0;
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_pstrb = '0;
    m_rdata = '0; m_slverr = 1'b0; m_to = 1'b0;
  endtask

  task automatic compare();
    bit expv;
    expv = m_busy && (m_k >= m_done_k);
    check("cmd_ready", bus.cmd_ready, !m_busy);
    check("psel",      bus.PSEL,      m_busy && m_k >= 1 && m_k < m_done_k);
    check("penable",   bus.PENABLE,   m_busy && m_k >= 2 && m_k < m_done_k);
    check("rsp_valid", bus.rsp_valid, expv);
    check("paddr",     bus.PADDR,     m_paddr);
    check("pwrite",    bus.PWRITE,    m_pwrite);
    check("pwdata",    bus.PWDATA,    m_pwdata);
    check("pstrb",     bus.PSTRB,     m_pstrb);
    if (expv) begin
      check("rsp_rdata",   bus.rsp_rdata,   m_rdata);
      check("rsp_slverr",  bus.rsp_slverr,  m_slverr);
      check("rsp_timeout", bus.rsp_timeout, m_to);
    end
    if (bus.rsp_valid === 1'b1 && !seen) begin
      seen       = 1;
      obs_lat    = cyc - acc_cyc;
      obs_rdata  = bus.rsp_rdata;
      obs_slverr = bus.rsp_slverr;
      obs_to     = bus.rsp_timeout;
    end
  endtask

  // One clock cycle: check outputs, drive inputs for this cycle, advance model.
  task automatic step(input bit cv, input logic [AW-1:0] a, input bit wr,
                      input logic [DW-1:0] wd, input logic [SW-1:0] st, input int w,
                      input bit rr, input logic [DW-1:0] prd, input bit perr);
    bit access;
    @(negedge PCLK);
    cyc++;
    compare();
    bus.cmd_valid = cv;
    bus.cmd_addr  = a;
    bus.cmd_write = wr;
    bus.cmd_wdata = wd;
    bus.cmd_strb  = st;
    bus.rsp_ready = rr;
    bus.PRDATA    = prd;
    bus.PSLVERR   = perr;
    access = m_busy && m_k >= 2 && m_k < m_done_k;
    if (access) begin
      bus.PREADY = (m_k == 2 + m_w);
      if (m_k == 2 + m_w) begin
        m_rdata = m_pwrite ? '0 : prd; m_slverr = perr; m_to = 1'b0;
      end else if (m_k == T + 2) begin
        m_rdata = '0; m_slverr = 1'b1; m_to = 1'b1;
      end
    end else begin
      bus.PREADY = 1'($urandom);
    end
    if (!m_busy) begin
      if (cv) begin
        m_busy   = 1; m_k = 1; m_w = w;
        m_done_k = (w <= T) ? 3 + w : T + 3;
        m_paddr  = a; m_pwrite = wr;
        m_pwdata = wr ? wd : '0;
        m_pstrb  = wr ? st : '0;
        acc_cyc  = cyc; seen = 0; obs_lat = -1;
      end
    end else if (m_k >= m_done_k && rr) begin
      m_busy = 0; hs_cyc = cyc;
    end else begin
      m_k++;
    end
  endtask

  // Issue one command (w = PREADY-low cycles), hold rsp_ready low for bp
  // response cycles, keep cmd_valid at cvh while the transfer is in flight.
  task automatic run_txn(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st, input int w, input logic [DW-1:0] prd,
                         input bit perr, input int bp, input bit cvh);
    int n, held;
    bit rr;
    step(1'b1, a, wr, wd, st, w, 1'b0, prd, perr);
    n = 0; held = 0;
    while (m_busy && n < 60) begin
      rr = 1'b0;
      if (m_k >= m_done_k) begin
        rr = (held >= bp);
        held++;
      end
      step(cvh, $urandom, 1'($urandom), $urandom, 4'($urandom), 0, rr, prd, perr);
      n++;
    end
    if (m_busy) begin
      total++; bad++;
      $display("FAIL txn_bound: transfer to 0x%0h still open after %0d cycles", a, n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int h, w;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0; bus.cmd_strb = '0; bus.rsp_ready = 1'b0;
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
    model_reset();
    seen = 1; obs_lat = -1; acc_cyc = 0; hs_cyc = 0;

    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_psel", bus.PSEL, 0);
    check("rst_penable", bus.PENABLE, 0);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pwdata", bus.PWDATA, 0);
    check("rst_pstrb", bus.PSTRB, 0);
    check("rst_pwrite", bus.PWRITE, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_slverr", bus.rsp_slverr, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    run_txn(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 32'h7777_7777, 1'b0, 0, 1'b0);
    check("wr0_latency", obs_lat, 3);
    check("wr0_rdata", obs_rdata, 0);
    check("wr0_slverr", obs_slverr, 0);
    check("wr0_timeout", obs_to, 0);

    run_txn(32'h2000_0040, 1'b0, 32'h1234_5678, 4'hF, 3, 32'hA5A5_0001, 1'b0, 0, 1'b0);
    check("rd3_latency", obs_lat, 6);
    check("rd3_rdata", obs_rdata, 32'hA5A5_0001);
    check("rd3_timeout", obs_to, 0);

    run_txn(32'h44, 1'b0, '0, 4'h0, 1, 32'h0BAD_F00D, 1'b1, 0, 1'b0);
    check("err_slverr", obs_slverr, 1);
    check("err_timeout", obs_to, 0);
    check("err_rdata", obs_rdata, 32'h0BAD_F00D);

    run_txn(32'h80, 1'b0, '0, 4'h0, 100, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    check("to_latency", obs_lat, T + 3);
    check("to_rdata", obs_rdata, 0);
    check("to_slverr", obs_slverr, 1);
    check("to_timeout", obs_to, 1);

    run_txn(32'h84, 1'b0, '0, 4'h0, T - 1, 32'h0000_0444, 1'b0, 0, 1'b0);
    check("w3_latency", obs_lat, 6);
    check("w3_timeout", obs_to, 0);

    run_txn(32'h88, 1'b0, '0, 4'h0, T, 32'h1111_2222, 1'b0, 0, 1'b0);
    check("wlim_latency", obs_lat, 7);
    check("wlim_timeout", obs_to, 0);
    check("wlim_rdata", obs_rdata, 32'h1111_2222);

    run_txn(32'h100, 1'b1, 32'hCAFE_0001, 4'h3, 0, '0, 1'b0, 5, 1'b1);
    h = hs_cyc;
    check("bp_latency", obs_lat, 3);
    run_txn(32'h104, 1'b1, 32'hCAFE_0002, 4'hC, 0, '0, 1'b0, 0, 1'b0);
    check("bp_next_accept", acc_cyc - h, 1);

    step(1'b1, 32'h300, 1'b0, '0, 4'h0, 6, 1'b0, '0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, '0, 4'h0, 0, 1'b0, '0, 1'b0);
    #2;
    PRESETn = 1'b0;
    #1;
    check("mid_rst_psel", bus.PSEL, 0);
    check("mid_rst_penable", bus.PENABLE, 0);
    check("mid_rst_paddr", bus.PADDR, 0);
    check("mid_rst_pwrite", bus.PWRITE, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 0);
    model_reset();
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (4) step(1'b0, '0, 1'b0, '0, 4'h0, 0, 1'b1, '0, 1'b0);
    run_txn(32'h308, 1'b0, '0, 4'h0, 2, 32'h5555_AAAA, 1'b0, 0, 1'b0);
    check("post_rst_latency", obs_lat, 5);
    check("post_rst_rdata", obs_rdata, 32'h5555_AAAA);

    repeat (1500) begin
      w = ($urandom % 4 == 0) ? T + 1 + int'($urandom % 3) : int'($urandom_range(0, T));
      step($urandom % 3 != 0, $urandom, 1'($urandom), $urandom, 4'($urandom), w,
           1'($urandom), $urandom, $urandom % 4 == 0);
    end
    for (int i = 0; i < 40 && m_busy; i++)
      step(1'b0, '0, 1'b0, '0, 4'h0, 0, 1'b1, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 4'h0, 0, 1'b1, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
